sram_pingpong_ctrl: RTL and testbench
=====================================

Name: sram_pingpong_ctrl

Overview:
- Single-clock sequencer for the dual-bank ping-pong frame store built from SRAM1/SRAM2 and their bank-select mux.
- Takes decoded 16-bit pixels on a valid/ready write port and serves encoder reads on a req/ready read port.
- Generates the write-channel (CH2) and read-channel (CH1) address and strobe timing, plus the bank-select flag.
- Swaps banks on a frame-start pulse once both channels are idle.

Parameters:
- FRAME_WORDS, 20'd307200: words per frame buffer (640x480); also the write limit and read wrap point.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; requests a bank swap
- wr_valid  in  1  write data valid
- wr_data  in  16  pixel to store
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- rd_req  in  1  read request
- rd_ready  out  1  read accepted when rd_req && rd_ready
- rd_data  out  16  read result
- rd_valid  out  1  one-cycle pulse; rd_data valid
- wr_ovf  out  1  sticky: a write arrived after FRAME_WORDS words this frame
- sram_flag  out  1  bank select: 1 = SRAM1 write / SRAM2 read, 0 = the reverse
- addr_CH2  out  20  write address
- datain_CH2  out  16  write data
- ce_CH2  out  1  write chip enable, active low
- we_CH2  out  1  write enable, active low
- oe_CH2  out  1  write output enable; tied to 1
- addr_CH1  out  20  read address
- dataout_CH1  in  16  read data from the selected bank
- ce_CH1  out  1  read chip enable, active low
- oe_CH1  out  1  read output enable, active low
- we_CH1  out  1  read write enable; tied to 1

Behaviour:
- Clock and reset: one clock domain. All outputs except the ready signals are registered.
- Reset values: sram_flag=0, addr_CH1/CH2=0, datain_CH2=0, ce_CH1/CH2=1, we_CH2=1, oe_CH1=1, rd_data=0, rd_valid=0, wr_ovf=0, wr_addr=0, rd_addr=0, swap_pend=0, both FSMs in IDLE.
- Reset mid-access: all strobes go inactive immediately, and any in-flight access is abandoned.
- Write FSM states: W_IDLE -> W_WE1 -> W_WE2 -> W_HOLD -> W_IDLE.
  - wr_ready = (W_IDLE && !swap_pend), combinational.
  - Handshake at cycle T: addr_CH2 <= wr_addr and datain_CH2 <= wr_data at T+1.
  - ce_CH2=0 from T+1 to T+3. we_CH2=0 at T+1 and T+2; we_CH2=1 at T+3 (data hold). ce_CH2=1 at T+4.
  - wr_addr increments on each accepted write.
  - Throughput: one write per 4 cycles.
- Write overflow: if wr_addr==FRAME_WORDS at handshake, the word is accepted but dropped. No strobes are issued, the FSM stays in W_IDLE, and wr_ovf is set.
- Read FSM states: R_IDLE -> R_OE1 -> R_OE2 -> R_IDLE.
  - rd_ready = (R_IDLE && !swap_pend), combinational.
  - Handshake at T: addr_CH1 <= rd_addr; ce_CH1=0 and oe_CH1=0 at T+1 and T+2.
  - dataout_CH1 is sampled at the end of T+2. rd_data updates and rd_valid=1 at T+3, for one cycle. ce_CH1 and oe_CH1 return to 1 at T+3.
  - rd_addr wraps from FRAME_WORDS-1 to 0.
  - Throughput: one read per 3 cycles.
- Bank swap:
  - frame_start sets swap_pend; a second frame_start while swap_pend is already set is absorbed.
  - In the first cycle with swap_pend=1 and both FSMs idle: sram_flag toggles, wr_addr=0, rd_addr=0, wr_ovf=0, swap_pend=0.
  - Worst-case swap latency is 4 cycles after frame_start.
- Simultaneous events:
  - frame_start in the same cycle as a wr or rd handshake: the handshake completes first, then the swap occurs.
  - Read and write proceed concurrently and independently; they never touch the same bank.
- sram_flag changes only when ce_CH1=ce_CH2=1, so the bank mux never switches mid-access.

Test Plan:
- Reset: assert rst_n=0 mid-write (we_CH2=0) -> all strobes go to 1 immediately, sram_flag=0, wr_ready=1 after release.
- Single write: wr_data=16'hA5A5 at T -> addr_CH2=0, we_CH2 low at T+1 and T+2, high at T+3 with ce_CH2=0, ce_CH2=1 at T+4, next write lands at addr 1.
- Single read: SRAM model returns 16'h1234 at addr 0, rd_req at T -> oe_CH1 low at T+1 and T+2, rd_valid=1 with rd_data=16'h1234 at T+3.
- Swap during an access: frame_start at T+1 of a write -> sram_flag toggles at T+4, both address counters are 0, wr_ready and rd_ready are 0 from T+2 until the swap.
- Overflow and wrap: FRAME_WORDS=4; 5 writes -> 5th causes no strobes and wr_ovf=1; 5 reads -> addresses 0,1,2,3,0; next frame_start clears wr_ovf.
- Concurrent streams: continuous wr_valid and rd_req for 100 cycles -> exactly 25 writes and 33 reads complete, with no ce overlap across sram_flag toggles.

Source files
------------

// File: rtl/sram_pingpong_ctrl.sv
// sram_pingpong_ctrl: sequences SRAM1/SRAM2 as a ping-pong frame store with a write channel (CH2) and a read channel (CH1)
// Ports: frame_start requests a bank swap; wr_valid/wr_ready/wr_data accept pixels; rd_req/rd_ready issue reads
//   and rd_data/rd_valid return them; wr_ovf flags writes beyond FRAME_WORDS; sram_flag selects the banks
//   (1 = SRAM1 write / SRAM2 read); addr/datain/ce/we/oe_CH2 drive the write bank; addr/dataout/ce/oe/we_CH1 the read bank.
module sram_pingpong_ctrl #(
  parameter logic [19:0] FRAME_WORDS = 20'd307200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        rd_req,
  output logic        rd_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        wr_ovf,
  output logic        sram_flag,
  output logic [19:0] addr_CH2,
  output logic [15:0] datain_CH2,
  output logic        ce_CH2,
  output logic        we_CH2,
  output logic        oe_CH2,
  output logic [19:0] addr_CH1,
  input  logic [15:0] dataout_CH1,
  output logic        ce_CH1,
  output logic        oe_CH1,
  output logic        we_CH1
);
  typedef enum logic [1:0] {W_IDLE, W_WE1, W_WE2, W_HOLD} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_OE1, R_OE2} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [19:0] wr_addr;
  logic [19:0] rd_addr;
  logic swap_pend;
  logic wr_hs;
  logic rd_hs;
  logic swap_go;
  assign wr_ready = w_state == W_IDLE && !swap_pend;
  assign rd_ready = r_state == R_IDLE && !swap_pend;
  assign wr_hs = wr_valid && wr_ready;
  assign rd_hs = rd_req && rd_ready;
  // both channels are idle after this edge, so the bank mux flips while every strobe is off
  assign swap_go = swap_pend && (w_state == W_IDLE || w_state == W_HOLD) && (r_state == R_IDLE || r_state == R_OE2);
  assign oe_CH2 = 1'b1;
  assign we_CH1 = 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_state <= W_IDLE;
      wr_addr <= '0;
      wr_ovf <= 1'b0;
      addr_CH2 <= '0;
      datain_CH2 <= '0;
      ce_CH2 <= 1'b1;
      we_CH2 <= 1'b1;
    end else begin
      case (w_state)
        W_IDLE:
          if (wr_hs) begin
            if (wr_addr >= FRAME_WORDS) wr_ovf <= 1'b1;
            else begin
              w_state <= W_WE1;
              addr_CH2 <= wr_addr;
              datain_CH2 <= wr_data;
              ce_CH2 <= 1'b0;
              we_CH2 <= 1'b0;
              wr_addr <= wr_addr + 20'd1;
            end
          end
        W_WE1: w_state <= W_WE2;
        W_WE2: begin
          w_state <= W_HOLD;
          we_CH2 <= 1'b1;
        end
        default: begin
          w_state <= W_IDLE;
          ce_CH2 <= 1'b1;
        end
      endcase
      if (swap_go) begin
        wr_addr <= '0;
        wr_ovf <= 1'b0;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= R_IDLE;
      rd_addr <= '0;
      addr_CH1 <= '0;
      ce_CH1 <= 1'b1;
      oe_CH1 <= 1'b1;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (r_state)
        R_IDLE:
          if (rd_hs) begin
            r_state <= R_OE1;
            addr_CH1 <= rd_addr;
            ce_CH1 <= 1'b0;
            oe_CH1 <= 1'b0;
            rd_addr <= rd_addr == FRAME_WORDS - 20'd1 ? '0 : rd_addr + 20'd1;
          end
        R_OE1: r_state <= R_OE2;
        default: begin
          r_state <= R_IDLE;
          ce_CH1 <= 1'b1;
          oe_CH1 <= 1'b1;
          rd_data <= dataout_CH1;
          rd_valid <= 1'b1;
        end
      endcase
      if (swap_go) rd_addr <= '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sram_flag <= 1'b0;
      swap_pend <= 1'b0;
    end else if (swap_go) begin
      sram_flag <= !sram_flag;
      swap_pend <= 1'b0;
    end else if (frame_start) swap_pend <= 1'b1;
endmodule

// File: tb/tb_sram_pingpong_ctrl.sv
// tb_sram_pingpong_ctrl: checks sram_pingpong_ctrl against a cycle-count reference model and two SRAM bank models
module tb_sram_pingpong_ctrl;
  localparam int FW = 32;
  localparam int AW = $clog2(FW);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic wr_valid = 1'b0;
  logic rd_req = 1'b0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data, datain_CH2, dataout_CH1;
  logic wr_ready, rd_ready, rd_valid, wr_ovf, sram_flag, ce_CH2, we_CH2, oe_CH2, ce_CH1, oe_CH1, we_CH1;
  logic [19:0] addr_CH2, addr_CH1;
  logic [15:0] mem [2][FW] = '{default: '0};
  logic [15:0] exp_mem [2][FW];
  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int dwr = 0;
  int drd = 0;
  int wcnt = 0;
  int rcnt = 0;
  int m_waddr = 0;
  int m_raddr = 0;
  int w_at = 0;
  int r_at = 0;
  bit m_flag = 0;
  bit m_ovf = 0;
  bit m_pend = 0;
  logic [15:0] w_dat = '0;
  int due_q[$];
  logic [15:0] dat_q[$];
  sram_pingpong_ctrl #(.FRAME_WORDS(20'(FW))) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_ovf(wr_ovf), .sram_flag(sram_flag),
    .addr_CH2(addr_CH2), .datain_CH2(datain_CH2), .ce_CH2(ce_CH2), .we_CH2(we_CH2), .oe_CH2(oe_CH2),
    .addr_CH1(addr_CH1), .dataout_CH1(dataout_CH1), .ce_CH1(ce_CH1), .oe_CH1(oe_CH1), .we_CH1(we_CH1)
  );
  always #5 clk = ~clk;
  // bank 0 = SRAM1, bank 1 = SRAM2; SRAM1 word 0 holds 16'h1234 out of reset
  always @(posedge clk)
    if (!rst_n) mem[0][0] <= 16'h1234;
    else if (!ce_CH2 && !we_CH2 && addr_CH2 < 20'(FW)) mem[sram_flag ? 0 : 1][addr_CH2[AW-1:0]] <= datain_CH2;
  assign dataout_CH1 = (!ce_CH1 && !oe_CH1 && addr_CH1 < 20'(FW)) ? mem[sram_flag ? 1 : 0][addr_CH1[AW-1:0]] : 16'hDEAD;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic mreset();
    wcnt = 0; rcnt = 0; m_waddr = 0; m_raddr = 0;
    m_flag = 0; m_ovf = 0; m_pend = 0;
    due_q.delete(); dat_q.delete();
    exp_mem[0][0] = 16'h1234;
  endtask
  // one clock of stimulus: predict readiness, update the model at the edge, then check every registered output
  task automatic cyc(input bit wv, input bit rq, input bit fs, input logic [15:0] d);
    bit wm, rm, pf, ev;
    int wn, rn;
    wr_valid = wv; rd_req = rq; frame_start = fs; wr_data = d;
    wm = wcnt == 0 && !m_pend;
    rm = rcnt == 0 && !m_pend;
    chk("wr_ready", 32'(wr_ready), 32'(wm));
    chk("rd_ready", 32'(rd_ready), 32'(rm));
    if (wv && wr_ready) dwr++;
    wn = wcnt > 0 ? wcnt - 1 : 0;
    rn = rcnt > 0 ? rcnt - 1 : 0;
    if (wv && wm && m_waddr < FW) begin
      exp_mem[m_flag ? 0 : 1][m_waddr] = d;
      w_at = m_waddr; w_dat = d; m_waddr++; wn = 3;
    end else if (wv && wm) m_ovf = 1;
    if (rq && rm) begin
      due_q.push_back(ncyc + 3);
      dat_q.push_back(exp_mem[m_flag ? 1 : 0][m_raddr]);
      r_at = m_raddr; m_raddr = (m_raddr + 1) % FW; rn = 2;
    end
    pf = m_flag;
    if (m_pend && wn == 0 && rn == 0) begin
      m_flag = !m_flag; m_waddr = 0; m_raddr = 0; m_ovf = 0; m_pend = 0;
    end else if (fs) m_pend = 1;
    wcnt = wn; rcnt = rn;
    @(posedge clk); #1;
    ncyc++;
    chk("sram_flag", 32'(sram_flag), 32'(m_flag));
    chk("wr_ovf", 32'(wr_ovf), 32'(m_ovf));
    chk("ce_CH2", 32'(ce_CH2), 32'(wcnt == 0));
    chk("we_CH2", 32'(we_CH2), 32'(wcnt < 2));
    if (wcnt == 3) begin
      chk("addr_CH2", 32'(addr_CH2), 32'(w_at));
      chk("datain_CH2", 32'(datain_CH2), 32'(w_dat));
    end
    chk("ce_CH1", 32'(ce_CH1), 32'(rcnt == 0));
    chk("oe_CH1", 32'(oe_CH1), 32'(rcnt == 0));
    if (rcnt == 2) chk("addr_CH1", 32'(addr_CH1), 32'(r_at));
    if (m_flag != pf) chk("swap_idle", 32'({ce_CH1, ce_CH2}), 32'd3);
    ev = due_q.size() > 0 && due_q[0] == ncyc;
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    if (ev) begin
      chk("rd_data", 32'(rd_data), 32'(dat_q.pop_front()));
      void'(due_q.pop_front());
    end
    if (rd_valid) drd++;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 16'h0);
  endtask
  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < FW; i++) exp_mem[b][i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sram_flag", 32'(sram_flag), 32'd0);
    chk("rst_ce_CH1", 32'(ce_CH1), 32'd1);
    chk("rst_ce_CH2", 32'(ce_CH2), 32'd1);
    chk("rst_we_CH2", 32'(we_CH2), 32'd1);
    chk("rst_oe_CH1", 32'(oe_CH1), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_wr_ovf", 32'(wr_ovf), 32'd0);
    chk("rst_addr_CH1", 32'(addr_CH1), 32'd0);
    chk("rst_addr_CH2", 32'(addr_CH2), 32'd0);
    chk("rst_datain_CH2", 32'(datain_CH2), 32'd0);
    chk("tie_oe_CH2", 32'(oe_CH2), 32'd1);
    chk("tie_we_CH1", 32'(we_CH1), 32'd1);
    rst_n = 1'b1;
    wr_valid = 1'b1; wr_data = 16'hFFFF;
    chk("pre_wr_ready", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk("midwr_we_CH2", 32'(we_CH2), 32'd0);
    chk("midwr_ce_CH2", 32'(ce_CH2), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ce_CH2", 32'(ce_CH2), 32'd1);
    chk("arst_we_CH2", 32'(we_CH2), 32'd1);
    chk("arst_ce_CH1", 32'(ce_CH1), 32'd1);
    chk("arst_oe_CH1", 32'(oe_CH1), 32'd1);
    chk("arst_addr_CH2", 32'(addr_CH2), 32'd0);
    chk("arst_sram_flag", 32'(sram_flag), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mreset();
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_rd_ready", 32'(rd_ready), 32'd1);
    cyc(1, 0, 0, 16'hA5A5);
    chk("w1_addr", 32'(addr_CH2), 32'd0);
    chk("w1_data", 32'(datain_CH2), 32'hA5A5);
    chk("w1_we_t1", 32'(we_CH2), 32'd0);
    idle(1);
    chk("w1_we_t2", 32'(we_CH2), 32'd0);
    idle(1);
    chk("w1_we_t3", 32'(we_CH2), 32'd1);
    chk("w1_ce_t3", 32'(ce_CH2), 32'd0);
    idle(1);
    chk("w1_ce_t4", 32'(ce_CH2), 32'd1);
    cyc(0, 1, 0, 16'h0);
    chk("r1_oe_t1", 32'(oe_CH1), 32'd0);
    idle(1);
    chk("r1_oe_t2", 32'(oe_CH1), 32'd0);
    idle(1);
    chk("r1_valid", 32'(rd_valid), 32'd1);
    chk("r1_data", 32'(rd_data), 32'h1234);
    idle(1);
    chk("r1_valid_drop", 32'(rd_valid), 32'd0);
    cyc(1, 0, 0, 16'h5A5A);
    chk("w2_addr", 32'(addr_CH2), 32'd1);
    idle(3);
    cyc(1, 0, 0, 16'($urandom));
    cyc(0, 0, 1, 16'h0);
    chk("swp_wr_ready_t2", 32'(wr_ready), 32'd0);
    chk("swp_rd_ready_t2", 32'(rd_ready), 32'd0);
    cyc(0, 0, 1, 16'h0);
    chk("swp_wr_ready_t3", 32'(wr_ready), 32'd0);
    idle(1);
    chk("swp_flag_t4", 32'(sram_flag), 32'd1);
    chk("swp_wr_ready_t4", 32'(wr_ready), 32'd1);
    cyc(1, 1, 0, 16'($urandom));
    chk("swp_addr_CH2", 32'(addr_CH2), 32'd0);
    chk("swp_addr_CH1", 32'(addr_CH1), 32'd0);
    idle(2);
    chk("swp_bank_data", 32'(rd_data), 32'hA5A5);
    idle(1);
    for (int i = 0; i < FW - 1; i++) begin
      cyc(1, 0, 0, 16'($urandom));
      chk("fill_addr", 32'(addr_CH2), 32'(i + 1));
      idle(3);
    end
    chk("pre_ovf", 32'(wr_ovf), 32'd0);
    cyc(1, 0, 0, 16'($urandom));
    chk("ovf_set", 32'(wr_ovf), 32'd1);
    chk("ovf_no_ce", 32'(ce_CH2), 32'd1);
    idle(3);
    for (int i = 0; i < FW + 1; i++) begin
      cyc(0, 1, 0, 16'h0);
      chk("wrap_addr", 32'(addr_CH1), 32'((i + 1) % FW));
      idle(2);
    end
    cyc(0, 0, 1, 16'h0);
    idle(3);
    chk("ovf_clear", 32'(wr_ovf), 32'd0);
    chk("flag_back", 32'(sram_flag), 32'd0);
    repeat (FW) begin
      cyc(0, 1, 0, 16'h0);
      idle(2);
    end
    dwr = 0; drd = 0;
    repeat (100) cyc(1, 1, 0, 16'($urandom));
    chk("conc_writes", 32'(dwr), 32'd25);
    chk("conc_reads", 32'(drd), 32'd33);
    idle(4);
    cyc(0, 0, 1, 16'h0);
    idle(4);
    repeat (25) begin
      cyc(0, 1, 0, 16'h0);
      idle(2);
    end
    repeat (400) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0, 16'($urandom));
    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
